slice_sequencer: RTL and testbench

Controller that feeds a wide word through a fixed-width bit slicer one slice per beat, turning an INPUT_DATA_WIDTH word into NUM_SLICES consecutive SLICE_WIDTH slices.
- Valid/ready handshake on both sides.
- Sits between a wide producer (e.g. a packetiser or ADC word bus) and a narrow consumer (serial link, narrow FIFO).
- Slice order is MSB-first or LSB-first by parameter.

---
 rtl/slice_seq_pkg.sv | 25 ++
 rtl/slice_sequencer_shift.sv | 40 ++++
 rtl/slice_sequencer.sv | 129 ++++++++++++
 tb/tb_slice_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/slice_seq_pkg.sv
// Shared types and helpers for the slice sequencer: state encoding, clog2,
// and the supported ARCHITECTURE names.
package slice_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam ARCH_BEHAVIORAL = "BEHAVIORAL";

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    int tmp;
    res = 0;
    tmp = value - 1;
    while (tmp > 0) begin
      res++;
      tmp = tmp >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/slice_sequencer_shift.sv
// Wide load / slice-wide shift register. The output slice is read straight
// from the register, and the shift always moves data toward the output end.
module slice_shift_reg #(
  parameter int DATA_W    = 32,
  parameter int SLICE_W   = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [DATA_W-1:0]  din,
  output logic [SLICE_W-1:0] slice
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = MSB_FIRST ? (data_q << SLICE_W) : (data_q >> SLICE_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign slice = data_q[DATA_W-1 -: SLICE_W];
    end else begin : g_lsb
      assign slice = data_q[SLICE_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/slice_sequencer.sv
// Wide-word to narrow-slice sequencer with valid/ready on both sides.
// Optional per-word slice count is enabled by defining SLICE_SEQ_LEN_EN.
module slice_sequencer
  import slice_seq_pkg::*;
#(
  parameter          BLOCK_NAME        = "slice_sequencer",
  parameter int      X                 = 0,
  parameter int      Y                 = 0,
  parameter int      DX                = 0,
  parameter int      DY                = 0,
  parameter          ARCHITECTURE      = "BEHAVIORAL",
  parameter int      INPUT_DATA_WIDTH  = 32,
  parameter int      SLICE_WIDTH       = 8,
  parameter int      OFFSET_REL_TO_MSB = 1,
  localparam int     NUM_SLICES        = INPUT_DATA_WIDTH / SLICE_WIDTH,
  localparam int     IDX_W             = clog2(NUM_SLICES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUT_DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
`ifdef SLICE_SEQ_LEN_EN
  input  logic [IDX_W-1:0]            in_len,
`endif
  output logic [SLICE_WIDTH-1:0]      out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // Elaboration-time parameter sanity.
  generate
    if (ARCHITECTURE != ARCH_BEHAVIORAL) begin : g_bad_arch
      $error("%s: unsupported ARCHITECTURE", BLOCK_NAME);
    end
    if ((INPUT_DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_width
      $error("%s: INPUT_DATA_WIDTH not a multiple of SLICE_WIDTH", BLOCK_NAME);
    end
    if (NUM_SLICES < 2) begin : g_bad_slices
      $error("%s: NUM_SLICES must be at least 2", BLOCK_NAME);
    end
    if ((X < 0) || (Y < 0) || (DX < 0) || (DY < 0)) begin : g_bad_place
      $error("%s: negative placement parameter", BLOCK_NAME);
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_idx;
  logic             accept;
  logic             load;
  logic             shift;

`ifdef SLICE_SEQ_LEN_EN
  // Word length travels with the word; out-of-range lengths clamp to a full word.
  logic [IDX_W-1:0] last_idx_q, last_idx_d, len_clamp;

  always_comb begin
    len_clamp = (int'(in_len) >= NUM_SLICES) ? LAST_IDX : in_len;
    last_idx_d = accept ? len_clamp : last_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_idx_q <= LAST_IDX;
    else     last_idx_q <= last_idx_d;
  end

  assign last_idx = last_idx_q;
`else
  assign last_idx = LAST_IDX;
`endif

  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign out_index = idx_q;
  assign out_last  = (state_q == ST_SEND) && (idx_q == last_idx);
  // The out_ready -> in_ready path lets the next word land on the last beat.
  assign in_ready  = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (accept) begin
      load    = 1'b1;
      idx_d   = '0;
      state_d = ST_SEND;
    end else if ((state_q == ST_SEND) && out_ready) begin
      if (out_last) begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end else begin
        shift = 1'b1;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  slice_shift_reg #(
    .DATA_W   (INPUT_DATA_WIDTH),
    .SLICE_W  (SLICE_WIDTH),
    .MSB_FIRST(OFFSET_REL_TO_MSB != 0)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (in_data),
    .slice(out_data)
  );

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench: an MSB-first and an LSB-first sequencer share one stimulus
// stream and are checked against hand-computed slice sequences.
module tb_slice_sequencer;

  localparam int W  = 32;
  localparam int SW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          out_ready;
  logic [IW-1:0] in_len;
  logic [2:0]    len7;

  logic          in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [SW-1:0] out_data_m;
  logic [IW-1:0] out_index_m;
  logic          in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [SW-1:0] out_data_l;
  logic [IW-1:0] out_index_l;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  slice_sequencer #(.OFFSET_REL_TO_MSB(1)) u_msb (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
`ifdef SLICE_SEQ_LEN_EN
    .in_len(in_len),
`endif
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_index(out_index_m), .out_last(out_last_m), .busy(busy_m)
  );

  slice_sequencer #(.OFFSET_REL_TO_MSB(0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
`ifdef SLICE_SEQ_LEN_EN
    .in_len(in_len),
`endif
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_index(out_index_l), .out_last(out_last_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One output beat: check both instances mid-cycle, then advance a cycle.
  task automatic beat(input string tag, input logic [7:0] em, input logic [7:0] el,
                      input logic [1:0] idx, input logic last, input logic rdy);
    @(negedge clk);
    chk({tag, ".vld_m"},  32'(out_valid_m), 32'd1);
    chk({tag, ".vld_l"},  32'(out_valid_l), 32'd1);
    chk({tag, ".busy"},   32'(busy_m),      32'd1);
    chk({tag, ".dat_m"},  32'(out_data_m),  32'(em));
    chk({tag, ".dat_l"},  32'(out_data_l),  32'(el));
    chk({tag, ".idx_m"},  32'(out_index_m), 32'(idx));
    chk({tag, ".idx_l"},  32'(out_index_l), 32'(idx));
    chk({tag, ".last_m"}, 32'(out_last_m),  32'(last));
    chk({tag, ".last_l"}, 32'(out_last_l),  32'(last));
    chk({tag, ".rdy_m"},  32'(in_ready_m),  32'(rdy));
    chk({tag, ".rdy_l"},  32'(in_ready_l),  32'(rdy));
    step();
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ".vld_m"},  32'(out_valid_m), 32'd0);
    chk({tag, ".vld_l"},  32'(out_valid_l), 32'd0);
    chk({tag, ".busy_m"}, 32'(busy_m),      32'd0);
    chk({tag, ".busy_l"}, 32'(busy_l),      32'd0);
    chk({tag, ".last"},   32'(out_last_m),  32'd0);
    chk({tag, ".rdy_m"},  32'(in_ready_m),  32'd1);
    chk({tag, ".rdy_l"},  32'(in_ready_l),  32'd1);
    step();
  endtask

  // Present a word in IDLE; it is accepted on the following edge.
  task automatic accept(input string tag, input logic [31:0] word);
    in_data  = word;
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".acc_rdy"}, 32'(in_ready_m),  32'd1);
    chk({tag, ".acc_vld"}, 32'(out_valid_m), 32'd0);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_len    = '1;
    len7      = 3'd7;
    step();
    @(negedge clk);
    chk("rst.vld",  32'(out_valid_m), 32'd0);
    chk("rst.last", 32'(out_last_m),  32'd0);
    chk("rst.idx",  32'(out_index_m), 32'd0);
    chk("rst.dat",  32'(out_data_m),  32'd0);
    chk("rst.datl", 32'(out_data_l),  32'd0);
    chk("rst.busy", 32'(busy_m),      32'd0);
    chk("rst.rdy",  32'(in_ready_m),  32'd1);
    step();
    rst = 1'b0;

    // Single word, free-flowing consumer.
    out_ready = 1'b1;
    accept("t1", 32'hA1B2C3D4);
    in_valid = 1'b0;
    beat("t1.s0", 8'hA1, 8'hD4, 2'd0, 1'b0, 1'b0);
    beat("t1.s1", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    beat("t1.s2", 8'hC3, 8'hB2, 2'd2, 1'b0, 1'b0);
    beat("t1.s3", 8'hD4, 8'hA1, 2'd3, 1'b1, 1'b1);
    idle_chk("t1.end");

    // Back-to-back words with the next word held valid.
    accept("b2b", 32'h01020304);
    in_data = 32'h05060708;
    beat("b2b.s0", 8'h01, 8'h04, 2'd0, 1'b0, 1'b0);
    beat("b2b.s1", 8'h02, 8'h03, 2'd1, 1'b0, 1'b0);
    beat("b2b.s2", 8'h03, 8'h02, 2'd2, 1'b0, 1'b0);
    beat("b2b.s3", 8'h04, 8'h01, 2'd3, 1'b1, 1'b1);
    in_valid = 1'b0;
    beat("b2b.s4", 8'h05, 8'h08, 2'd0, 1'b0, 1'b0);
    beat("b2b.s5", 8'h06, 8'h07, 2'd1, 1'b0, 1'b0);
    beat("b2b.s6", 8'h07, 8'h06, 2'd2, 1'b0, 1'b0);
    beat("b2b.s7", 8'h08, 8'h05, 2'd3, 1'b1, 1'b1);
    idle_chk("b2b.end");

    // Backpressure on the second slice.
    accept("bp", 32'hA1B2C3D4);
    in_valid = 1'b0;
    beat("bp.s0", 8'hA1, 8'hD4, 2'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    beat("bp.h0", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    beat("bp.h1", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    beat("bp.h2", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    beat("bp.s1", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    beat("bp.s2", 8'hC3, 8'hB2, 2'd2, 1'b0, 1'b0);
    beat("bp.s3", 8'hD4, 8'hA1, 2'd3, 1'b1, 1'b1);
    idle_chk("bp.end");

    // Reset in the middle of a word, then a clean word.
    accept("mr", 32'hA1B2C3D4);
    in_valid = 1'b0;
    beat("mr.s0", 8'hA1, 8'hD4, 2'd0, 1'b0, 1'b0);
    beat("mr.s1", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr.rst.vld",  32'(out_valid_m), 32'd0);
    chk("mr.rst.busy", 32'(busy_m),      32'd0);
    chk("mr.rst.rdy",  32'(in_ready_m),  32'd1);
    chk("mr.rst.idx",  32'(out_index_m), 32'd0);
    chk("mr.rst.dat",  32'(out_data_m),  32'd0);
    step();
    rst = 1'b0;
    accept("mr2", 32'h11223344);
    in_valid = 1'b0;
    beat("mr2.s0", 8'h11, 8'h44, 2'd0, 1'b0, 1'b0);
    beat("mr2.s1", 8'h22, 8'h33, 2'd1, 1'b0, 1'b0);
    beat("mr2.s2", 8'h33, 8'h22, 2'd2, 1'b0, 1'b0);
    beat("mr2.s3", 8'h44, 8'h11, 2'd3, 1'b1, 1'b1);
    idle_chk("mr2.end");

`ifdef SLICE_SEQ_LEN_EN
    // Short word: two slices only.
    in_len = 2'd1;
    accept("len1", 32'hA1B2C3D4);
    in_valid = 1'b0;
    beat("len1.s0", 8'hA1, 8'hD4, 2'd0, 1'b0, 1'b0);
    beat("len1.s1", 8'hB2, 8'hC3, 2'd1, 1'b1, 1'b1);
    idle_chk("len1.end");

    // Oversized length (7, truncated to the port width) gives a full word.
    in_len = len7[IW-1:0];
    accept("len7", 32'hA1B2C3D4);
    in_valid = 1'b0;
    beat("len7.s0", 8'hA1, 8'hD4, 2'd0, 1'b0, 1'b0);
    beat("len7.s1", 8'hB2, 8'hC3, 2'd1, 1'b0, 1'b0);
    beat("len7.s2", 8'hC3, 8'hB2, 2'd2, 1'b0, 1'b0);
    beat("len7.s3", 8'hD4, 8'hA1, 2'd3, 1'b1, 1'b1);
    idle_chk("len7.end");
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
